rv32_mod_branch_pred: RTL

RV32_MOD_BRANCH_PRED -- requirements
Module: rv32_mod_branch_pred

---
 rtl/rv32_mod_branch_pred_if.sv | 32 +++
 rtl/rv32_mod_branch_pred.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rv32_mod_branch_pred_if.sv
// Resolve-request / resolve-result handshake bundle for the RV32 branch predictor.
// master drives requests and out_ready; slave is the predictor.
interface rv32_mod_branch_pred_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      funct3;
    logic            is_cond;
    logic            is_jmp;
    logic            in_pred_taken;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc, rs1, rs2, funct3, is_cond, is_jmp, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_pc, out_taken, out_mispredict, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, rs1, rs2, funct3, is_cond, is_jmp, in_pred_taken, out_ready,
        output in_ready, out_valid, out_pc, out_taken, out_mispredict, out_illegal
    );
endinterface

// File: rtl/rv32_mod_branch_pred.sv
// RV32 branch resolver with a 2-bit-counter BHT for fetch prediction, a single
// output register stage and a saturating mispredict counter.
module rv32_mod_branch_pred #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_IDX_W = 6,
    parameter logic [1:0]  CNT_RESET = 2'b01
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XLEN-1:0]       pred_pc_i,
    output logic                  pred_taken_o,
    input  logic                  perf_clr_i,
    output logic [15:0]           perf_mispred_o,
    rv32_mod_branch_pred_if.slave bus
);
    localparam int unsigned BhtEntries = 1 << BHT_IDX_W;

    logic [1:0] bht_q [BhtEntries];

    logic [BHT_IDX_W-1:0] pred_idx;
    logic [BHT_IDX_W-1:0] upd_idx;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_taken_q, out_taken_d;
    logic            out_mispredict_q, out_mispredict_d;
    logic            out_illegal_q, out_illegal_d;
    logic [15:0]     perf_q, perf_d;

    logic       accept;
    logic       cond_true;
    logic       illegal_f3;
    logic       illegal;
    logic       taken;
    logic       mispredict;
    logic       bht_upd;
    logic [1:0] cnt_cur;
    logic [1:0] cnt_nxt;

    // Halfword granularity so compressed instructions get distinct entries.
    assign pred_idx = pred_pc_i[BHT_IDX_W:1];
    assign upd_idx  = bus.in_pc[BHT_IDX_W:1];

    // Read is the registered array value, so a same-cycle update is not bypassed.
    assign pred_taken_o = bht_q[pred_idx][1];

    assign bus.in_ready = !rst_i && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        cond_true  = 1'b0;
        illegal_f3 = 1'b0;
        case (bus.funct3)
            3'b000:  cond_true = (bus.rs1 == bus.rs2);
            3'b001:  cond_true = (bus.rs1 != bus.rs2);
            3'b100:  cond_true = ($signed(bus.rs1) <  $signed(bus.rs2));
            3'b101:  cond_true = ($signed(bus.rs1) >= $signed(bus.rs2));
            3'b110:  cond_true = (bus.rs1 <  bus.rs2);
            3'b111:  cond_true = (bus.rs1 >= bus.rs2);
            default: illegal_f3 = 1'b1;
        endcase
    end

    assign illegal    = bus.is_cond && !bus.is_jmp && illegal_f3;
    assign taken      = bus.is_jmp || (bus.is_cond && cond_true && !illegal_f3);
    assign mispredict = taken ^ bus.in_pred_taken;
    assign bht_upd    = accept && bus.is_cond && !bus.is_jmp && !illegal;

    always_comb begin
        cnt_cur = bht_q[upd_idx];
        cnt_nxt = cnt_cur;
        if (taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
        end
    end

    always_comb begin
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_taken_d      = out_taken_q;
        out_mispredict_d = out_mispredict_q;
        out_illegal_d    = out_illegal_q;
        if (accept) begin
            out_valid_d      = 1'b1;
            out_pc_d         = bus.in_pc;
            out_taken_d      = taken;
            out_mispredict_d = mispredict;
            out_illegal_d    = illegal;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (perf_clr_i) begin
            perf_d = '0;
        end else if (accept && mispredict && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_taken_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            perf_q           <= '0;
            for (int i = 0; i < BhtEntries; i++) begin
                bht_q[i] <= CNT_RESET;
            end
        end else begin
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_taken_q      <= out_taken_d;
            out_mispredict_q <= out_mispredict_d;
            out_illegal_q    <= out_illegal_d;
            perf_q           <= perf_d;
            if (bht_upd) begin
                bht_q[upd_idx] <= cnt_nxt;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_mispredict = out_mispredict_q;
    assign bus.out_illegal    = out_illegal_q;
    assign perf_mispred_o     = perf_q;
endmodule
